// File: rtl/y86_decode_stage_pkg.sv
// y86_pkg: shared constants for the PIPE decode slice.
//   - icode values HALT..POPQ
//   - fetch/decode status codes (AOK/HLT/ADR/INS)
//   - NOP bubble record loaded into the D register on reset/bubble
//   - default register ids for %rsp and "no register"
package y86_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    typedef enum logic [2:0] {
        STAT_AOK = 3'd1,
        STAT_HLT = 3'd2,
        STAT_ADR = 3'd3,
        STAT_INS = 3'd4
    } stat_t;

    typedef struct packed {
        logic [3:0] icode;
        logic [3:0] ifun;
        stat_t      stat;
    } bubble_t;

    localparam bubble_t NOP_BUBBLE = '{icode: INOP, ifun: 4'h0, stat: STAT_AOK};

    localparam int unsigned RSP_ID_DEF = 4;
    localparam int unsigned RNONE_DEF  = 15;

endpackage

// File: rtl/y86_decode_stage_if.sv
// Fetch -> decode bus.
//   master: fetch stage, drives f_* fields
//   slave : decode stage, samples f_* into the D register
//   f_valid          instruction present this cycle
//   f_icode, f_ifun  opcode fields (4 bits each)
//   f_rA, f_rB       register specifiers (REG_W)
//   f_valC, f_valP   constant word and next PC (WORD_W)
//   f_stat           fetch status
interface y86_decode_stage_if #(
    parameter int unsigned WORD_W = 64,
    parameter int unsigned REG_W  = 4
);
    logic              f_valid;
    logic [3:0]        f_icode;
    logic [3:0]        f_ifun;
    logic [REG_W-1:0]  f_rA;
    logic [REG_W-1:0]  f_rB;
    logic [WORD_W-1:0] f_valC;
    logic [WORD_W-1:0] f_valP;
    logic [2:0]        f_stat;

    modport master (output f_valid, f_icode, f_ifun, f_rA, f_rB, f_valC, f_valP, f_stat);
    modport slave  (input  f_valid, f_icode, f_ifun, f_rA, f_rB, f_valC, f_valP, f_stat);
endinterface

// File: rtl/y86_decode_stage_reg_select.sv
// y86_reg_select: combinational register-id selection for the decode stage.
//   icode, rA, rB           instruction fields from the D register
//   srcA, srcB, dstE, dstM  selected register ids (RNONE when unused)
//   illegal                 icode beyond POPQ
module y86_reg_select
    import y86_pkg::*;
#(
    parameter int unsigned REG_W  = 4,
    parameter int unsigned RSP_ID = RSP_ID_DEF,
    parameter int unsigned RNONE  = RNONE_DEF
) (
    input  logic [3:0]       icode,
    input  logic [REG_W-1:0] rA,
    input  logic [REG_W-1:0] rB,
    output logic [REG_W-1:0] srcA,
    output logic [REG_W-1:0] srcB,
    output logic [REG_W-1:0] dstE,
    output logic [REG_W-1:0] dstM,
    output logic             illegal
);
    localparam logic [REG_W-1:0] RSP_R   = REG_W'(RSP_ID);
    localparam logic [REG_W-1:0] RNONE_R = REG_W'(RNONE);

    always_comb begin
        srcA    = RNONE_R;
        srcB    = RNONE_R;
        dstE    = RNONE_R;
        dstM    = RNONE_R;
        illegal = (icode > IPOPQ);
        // Illegal icodes fall through every case, leaving all ids at RNONE.
        case (icode)
            IRRMOVQ: begin srcA = rA;                  dstE = rB;    end
            IIRMOVQ: begin                             dstE = rB;    end
            IRMMOVQ: begin srcA = rA;    srcB = rB;                  end
            IMRMOVQ: begin               srcB = rB;    dstM = rA;    end
            IOPQ:    begin srcA = rA;    srcB = rB;    dstE = rB;    end
            ICALL:   begin               srcB = RSP_R; dstE = RSP_R; end
            IRET:    begin srcA = RSP_R; srcB = RSP_R; dstE = RSP_R; end
            IPUSHQ:  begin srcA = rA;    srcB = RSP_R; dstE = RSP_R; end
            IPOPQ:   begin srcA = RSP_R; srcB = RSP_R; dstE = RSP_R; dstM = rA; end
            default: ;
        endcase
    end
endmodule

// File: rtl/y86_decode_stage.sv
// y86_decode_stage: D pipeline register plus decode for the PIPE processor.
//   clk, rst_n        clock, asynchronous active-low reset
//   fd (slave)        fetch bus (f_valid, f_icode, f_ifun, f_rA, f_rB, f_valC, f_valP, f_stat)
//   D_stall/D_bubble  hold / insert NOP bubble (stall wins)
//   E_icode, E_dstM   instruction in E, for load-use detection
//   D_*               registered fields
//   d_stat            D_stat, promoted to INS on an illegal icode
//   d_src*/d_dst*     decoded register ids, combinational from D
//   d_lu_hazard       load-use hazard request
//   stall_cnt         saturating count of stalled cycles
module y86_decode_stage
    import y86_pkg::*;
#(
    parameter int unsigned WORD_W = 64,
    parameter int unsigned REG_W  = 4,
    parameter int unsigned RSP_ID = RSP_ID_DEF,
    parameter int unsigned RNONE  = RNONE_DEF,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    y86_decode_stage_if.slave fd,
    input  logic              D_stall,
    input  logic              D_bubble,
    input  logic [3:0]        E_icode,
    input  logic [REG_W-1:0]  E_dstM,
    output logic              D_valid,
    output logic [3:0]        D_icode,
    output logic [3:0]        D_ifun,
    output logic [REG_W-1:0]  D_rA,
    output logic [REG_W-1:0]  D_rB,
    output logic [WORD_W-1:0] D_valC,
    output logic [WORD_W-1:0] D_valP,
    output logic [2:0]        d_stat,
    output logic [REG_W-1:0]  d_srcA,
    output logic [REG_W-1:0]  d_srcB,
    output logic [REG_W-1:0]  d_dstE,
    output logic [REG_W-1:0]  d_dstM,
    output logic              d_lu_hazard,
    output logic [CNT_W-1:0]  stall_cnt
);
    localparam logic [REG_W-1:0] RNONE_R = REG_W'(RNONE);

    logic [2:0]       D_stat;
    logic [REG_W-1:0] sel_srcA, sel_srcB, sel_dstE, sel_dstM;
    logic             sel_illegal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            D_valid <= 1'b0;
            D_icode <= NOP_BUBBLE.icode;
            D_ifun  <= NOP_BUBBLE.ifun;
            D_rA    <= RNONE_R;
            D_rB    <= RNONE_R;
            D_valC  <= '0;
            D_valP  <= '0;
            D_stat  <= NOP_BUBBLE.stat;
        end else if (!D_stall) begin
            // An explicit bubble and an empty fetch slot both load the NOP record.
            if (D_bubble || !fd.f_valid) begin
                D_valid <= 1'b0;
                D_icode <= NOP_BUBBLE.icode;
                D_ifun  <= NOP_BUBBLE.ifun;
                D_rA    <= RNONE_R;
                D_rB    <= RNONE_R;
                D_valC  <= '0;
                D_valP  <= '0;
                D_stat  <= NOP_BUBBLE.stat;
            end else begin
                D_valid <= 1'b1;
                D_icode <= fd.f_icode;
                D_ifun  <= fd.f_ifun;
                D_rA    <= fd.f_rA;
                D_rB    <= fd.f_rB;
                D_valC  <= fd.f_valC;
                D_valP  <= fd.f_valP;
                D_stat  <= fd.f_stat;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (D_stall && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 1'b1;
    end

    y86_reg_select #(
        .REG_W  (REG_W),
        .RSP_ID (RSP_ID),
        .RNONE  (RNONE)
    ) u_sel (
        .icode   (D_icode),
        .rA      (D_rA),
        .rB      (D_rB),
        .srcA    (sel_srcA),
        .srcB    (sel_srcB),
        .dstE    (sel_dstE),
        .dstM    (sel_dstM),
        .illegal (sel_illegal)
    );

    assign d_srcA = D_valid ? sel_srcA : RNONE_R;
    assign d_srcB = D_valid ? sel_srcB : RNONE_R;
    assign d_dstE = D_valid ? sel_dstE : RNONE_R;
    assign d_dstM = D_valid ? sel_dstM : RNONE_R;

    // An earlier fault status (HLT/ADR) takes precedence over INS.
    assign d_stat = (D_valid && sel_illegal && (D_stat == STAT_AOK)) ? STAT_INS : D_stat;

    assign d_lu_hazard = D_valid
                       && ((E_icode == IMRMOVQ) || (E_icode == IPOPQ))
                       && (E_dstM != RNONE_R)
                       && ((E_dstM == d_srcA) || (E_dstM == d_srcB));
endmodule
